spc7110_bank_map: RTL and testbench

SPC7110_BANK_MAP -- requirements
Module: spc7110_bank_map

---
 rtl/spc7110_defs.sv | 10 +
 rtl/spc7110_bank_map_if.sv | 40 ++++
 rtl/spc7110_strobe_edge.sv | 27 ++
 rtl/spc7110_bank_map.sv | 137 +++++++++++++
 tb/tb_spc7110_bank_map.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spc7110_defs.sv
// Shared SPC7110 constants: bank register port indices and
// the default SNES bank nibble of the first ROM window.
package spc7110_defs;

    localparam logic [3:0] PORT_SRAM     = 4'd0;
    localparam logic [3:0] PORT_SEL0     = 4'd1;
    localparam logic [3:0] BANK_BASE_DEF = 4'hD;
    localparam int         SRAM_BIT      = 7;

endpackage

// File: rtl/spc7110_bank_map_if.sv
// SNES-side bank register bus and address-translation port
// of the SPC7110 bank mapper.
interface spc7110_bank_map_if #(
    parameter int NUM_BANKS = 3,
    parameter int SEL_WIDTH = 3
);

    logic                           bank_sfc_enable;
    logic [3:0]                     sfc_port;
    logic                           sfc_rd;
    logic                           sfc_wr;
    logic [7:0]                     sfc_data_in;
    logic [7:0]                     sfc_data_out;
    logic                           sfc_data_valid;
    logic                           map_req;
    logic [7:0]                     map_bank;
    logic [SEL_WIDTH-1:0]           map_block;
    logic                           map_hit;
    logic                           map_ack;
    logic                           sram_enable;
    logic [NUM_BANKS*SEL_WIDTH-1:0] block_sel;
    logic                           update_pending;

    modport master (
        output bank_sfc_enable, sfc_port, sfc_rd, sfc_wr,
        output sfc_data_in, map_req, map_bank,
        input  sfc_data_out, sfc_data_valid,
        input  map_block, map_hit, map_ack,
        input  sram_enable, block_sel, update_pending
    );

    modport slave (
        input  bank_sfc_enable, sfc_port, sfc_rd, sfc_wr,
        input  sfc_data_in, map_req, map_bank,
        output sfc_data_out, sfc_data_valid,
        output map_block, map_hit, map_ack,
        output sram_enable, block_sel, update_pending
    );

endinterface

// File: rtl/spc7110_strobe_edge.sv
// Rise/fall pulse generator for a level strobe; a level already
// high out of reset is absorbed as history rather than an edge.
module spc7110_strobe_edge (
    input  logic CLK,
    input  logic RESET_N,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev;
    logic armed;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= level;
            armed <= 1'b1;
        end
    end

    assign rise = armed & level & ~prev;
    assign fall = armed & ~level & prev;

endmodule

// File: rtl/spc7110_bank_map.sv
// SPC7110 ROM bank window mapper: shadowed select registers,
// committed on strobe release, plus 1-cycle bank translation.
module spc7110_bank_map
    import spc7110_defs::*;
#(
    parameter int         NUM_BANKS = 3,
    parameter int         SEL_WIDTH = 3,
    parameter logic [3:0] BANK_BASE = BANK_BASE_DEF
) (
    input logic               CLK,
    input logic               RESET_N,
    spc7110_bank_map_if.slave bus
);

    logic                 wr_rise, wr_fall;
    logic                 rd_rise, rd_fall;
    logic                 wr_take, rd_take, wr_mapped;
    logic                 sh_sram, act_sram;
    logic [SEL_WIDTH-1:0] sh_sel  [NUM_BANKS];
    logic [SEL_WIDTH-1:0] act_sel [NUM_BANKS];
    logic [7:0]           rd_val;
    logic [3:0]           map_idx;
    logic                 lk_hit;
    logic [SEL_WIDTH-1:0] lk_block;
    logic                 unused_ok;

    spc7110_strobe_edge u_wr_edge (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .level   (bus.sfc_wr),
        .rise    (wr_rise),
        .fall    (wr_fall)
    );

    spc7110_strobe_edge u_rd_edge (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .level   (bus.sfc_rd),
        .rise    (rd_rise),
        .fall    (rd_fall)
    );

    assign wr_take   = wr_rise & bus.bank_sfc_enable;
    // A write rising alongside a read wins; the read is dropped.
    assign rd_take   = rd_rise & bus.bank_sfc_enable & ~wr_rise;
    assign map_idx   = bus.map_bank[7:4] - BANK_BASE;
    assign unused_ok = ^{rd_fall, bus.map_bank[3:0], bus.sfc_data_in};

    always_comb begin
        rd_val    = 8'h00;
        wr_mapped = 1'b0;
        if (bus.sfc_port == PORT_SRAM) begin
            rd_val    = {sh_sram, 7'b0};
            wr_mapped = 1'b1;
        end
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bus.sfc_port == PORT_SEL0 + 4'(i)) begin
                rd_val    = 8'(sh_sel[i]);
                wr_mapped = 1'b1;
            end
        end
    end

    always_comb begin
        lk_hit   = 1'b0;
        lk_block = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (map_idx == 4'(i)) begin
                lk_hit   = 1'b1;
                lk_block = act_sel[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sh_sram             <= 1'b0;
            act_sram            <= 1'b0;
            bus.update_pending  <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                sh_sel[i]  <= '0;
                act_sel[i] <= '0;
            end
        end else begin
            if (wr_take) begin
                if (bus.sfc_port == PORT_SRAM)
                    sh_sram <= bus.sfc_data_in[SRAM_BIT];
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (bus.sfc_port == PORT_SEL0 + 4'(i))
                        sh_sel[i] <= bus.sfc_data_in[SEL_WIDTH-1:0];
                end
                if (wr_mapped)
                    bus.update_pending <= 1'b1;
            end
            if (wr_fall) begin
                act_sram           <= sh_sram;
                act_sel            <= sh_sel;
                bus.update_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bus.sfc_data_out   <= 8'h00;
            bus.sfc_data_valid <= 1'b0;
        end else begin
            bus.sfc_data_valid <= rd_take;
            if (rd_take)
                bus.sfc_data_out <= rd_val;
        end
    end

    // Lookup reads the pre-edge active set, so a commit on the
    // same edge is only seen by the following request.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bus.map_ack   <= 1'b0;
            bus.map_hit   <= 1'b0;
            bus.map_block <= '0;
        end else begin
            bus.map_ack <= bus.map_req;
            if (bus.map_req) begin
                bus.map_hit   <= lk_hit;
                bus.map_block <= lk_block;
            end
        end
    end

    always_comb begin
        bus.sram_enable = act_sram;
        bus.block_sel   = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            bus.block_sel[i*SEL_WIDTH +: SEL_WIDTH] = act_sel[i];
    end

endmodule

// File: tb/tb_spc7110_bank_map.sv
// Randomized and directed bench for spc7110_bank_map against a
// cycle-level behavioural model of the register/commit rules.
module tb_spc7110_bank_map;

    localparam int NB   = 3;
    localparam int SW   = 3;
    localparam int BASE = 13;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLK = ~CLK;

    spc7110_bank_map_if #(.NUM_BANKS(NB), .SEL_WIDTH(SW)) bus ();

    spc7110_bank_map #(
        .NUM_BANKS (NB),
        .SEL_WIDTH (SW),
        .BANK_BASE (4'hD)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;

    int       m_sh [NB];
    int       m_act[NB];
    bit       m_ssh, m_sact, m_pend;
    bit       m_pwr, m_prd, m_first;
    bit       m_dval, m_ack, m_hit;
    int       m_dout, m_blk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        m_ssh = 0; m_sact = 0; m_pend = 0;
        m_pwr = 0; m_prd = 0; m_first = 1;
        m_dval = 0; m_ack = 0; m_hit = 0;
        m_dout = 0; m_blk = 0;
    endtask

    // Applies one clock edge of the register rules to the model.
    task automatic model_step();
        bit en = bus.bank_sfc_enable;
        bit wr = bus.sfc_wr;
        bit rd = bus.sfc_rd;
        int p  = int'(bus.sfc_port);
        int d  = int'(bus.sfc_data_in);
        bit wrise, wfall, rrise;
        int idx;
        wrise = !m_first && wr && !m_pwr;
        wfall = !m_first && !wr && m_pwr;
        rrise = !m_first && rd && !m_prd;
        m_first = 0;
        m_pwr = wr;
        m_prd = rd;
        m_dval = rrise && en && !wrise;
        if (m_dval) begin
            if (p == 0)
                m_dout = m_ssh ? 8'h80 : 8'h00;
            else if (p <= NB)
                m_dout = m_sh[p-1];
            else
                m_dout = 0;
        end
        m_ack = bus.map_req;
        if (bus.map_req) begin
            idx = ((int'(bus.map_bank) >> 4) - BASE) & 15;
            m_hit = idx < NB;
            m_blk = m_hit ? m_act[idx] : 0;
        end
        if (wrise && en) begin
            if (p == 0)
                m_ssh = d >= 128;
            else if (p <= NB)
                m_sh[p-1] = d % (1 << SW);
            if (p <= NB)
                m_pend = 1;
        end
        if (wfall) begin
            m_act  = m_sh;
            m_sact = m_ssh;
            m_pend = 0;
        end
    endtask

    task automatic compare();
        logic [NB*SW-1:0] bs;
        for (int i = 0; i < NB; i++)
            bs[i*SW +: SW] = SW'(m_act[i]);
        check("dval", bus.sfc_data_valid, m_dval);
        check("dout", bus.sfc_data_out, m_dout);
        check("ack", bus.map_ack, m_ack);
        check("hit", bus.map_hit, m_hit);
        check("blk", bus.map_block, m_blk);
        check("pend", bus.update_pending, m_pend);
        check("sram", bus.sram_enable, m_sact);
        check("bsel", bus.block_sel, bs);
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare();
    endtask

    task automatic idle();
        bus.bank_sfc_enable = 1'b1;
        bus.sfc_wr = 1'b0;
        bus.sfc_rd = 1'b0;
        bus.map_req = 1'b0;
    endtask

    task automatic wr_pulse(input int port, input int data, input int hold);
        bus.sfc_port = 4'(port);
        bus.sfc_data_in = 8'(data);
        bus.sfc_wr = 1'b1;
        repeat (hold) cyc();
        bus.sfc_wr = 1'b0;
        cyc();
    endtask

    task automatic rd_check(input int port, input int exp, string tag);
        bus.sfc_port = 4'(port);
        bus.sfc_rd = 1'b1;
        cyc();
        check({tag, "_val"}, bus.sfc_data_valid, 1);
        check({tag, "_data"}, bus.sfc_data_out, exp);
        bus.sfc_rd = 1'b0;
        cyc();
        check({tag, "_once"}, bus.sfc_data_valid, 0);
        check({tag, "_hold"}, bus.sfc_data_out, exp);
    endtask

    task automatic map_check(input int bank, input int blk, input int hit, string tag);
        bus.map_bank = 8'(bank);
        bus.map_req = 1'b1;
        cyc();
        check({tag, "_ack"}, bus.map_ack, 1);
        check({tag, "_blk"}, bus.map_block, blk);
        check({tag, "_hit"}, bus.map_hit, hit);
    endtask

    task automatic reset_outputs_zero(string tag);
        check({tag, "_dout"}, bus.sfc_data_out, 0);
        check({tag, "_dval"}, bus.sfc_data_valid, 0);
        check({tag, "_ack"}, bus.map_ack, 0);
        check({tag, "_hit"}, bus.map_hit, 0);
        check({tag, "_blk"}, bus.map_block, 0);
        check({tag, "_pend"}, bus.update_pending, 0);
        check({tag, "_sram"}, bus.sram_enable, 0);
        check({tag, "_bsel"}, bus.block_sel, 0);
    endtask

    initial begin
        idle();
        bus.sfc_port = 4'd0;
        bus.sfc_data_in = 8'h00;
        bus.map_bank = 8'h00;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset_outputs_zero("rst");
        RESET_N = 1'b1;
        cyc();

        // 4-cycle write of FF to window 0
        bus.sfc_port = 4'd1;
        bus.sfc_data_in = 8'hFF;
        bus.sfc_wr = 1'b1;
        cyc();
        check("w0_pend", bus.update_pending, 1);
        check("w0_pre", bus.block_sel[2:0], 0);
        repeat (3) cyc();
        check("w0_hold", bus.block_sel[2:0], 0);
        bus.sfc_wr = 1'b0;
        cyc();
        check("w0_commit", bus.block_sel[2:0], 7);
        check("w0_clr", bus.update_pending, 0);
        rd_check(1, 8'h07, "rb_w0");

        // long strobe with changing data: only the first value lands
        bus.sfc_port = 4'd2;
        bus.sfc_data_in = 8'h01;
        bus.sfc_wr = 1'b1;
        repeat (3) cyc();
        bus.sfc_data_in = 8'h05;
        repeat (7) cyc();
        bus.sfc_wr = 1'b0;
        cyc();
        check("once_w1", bus.block_sel[5:3], 1);

        wr_pulse(0, 8'h80, 1);
        wr_pulse(3, 8'h06, 1);
        rd_check(0, 8'h80, "rb_p0");
        rd_check(3, 8'h06, "rb_p3");
        rd_check(9, 8'h00, "rb_p9");
        check("sram_on", bus.sram_enable, 1);

        // simultaneous rise: write wins, no readback pulse
        bus.sfc_port = 4'd1;
        bus.sfc_data_in = 8'h03;
        bus.sfc_rd = 1'b1;
        bus.sfc_wr = 1'b1;
        cyc();
        check("rw_noval", bus.sfc_data_valid, 0);
        idle();
        cyc();

        wr_pulse(1, 2, 1);
        wr_pulse(2, 5, 1);
        wr_pulse(3, 7, 1);
        map_check(8'hD0, 2, 1, "mD0");
        map_check(8'hE3, 5, 1, "mE3");
        map_check(8'hFF, 7, 1, "mFF");
        map_check(8'hC0, 0, 0, "mC0");
        bus.map_req = 1'b0;
        cyc();

        // request on the commit edge sees the old window value
        bus.sfc_port = 4'd1;
        bus.sfc_data_in = 8'h04;
        bus.sfc_wr = 1'b1;
        cyc();
        bus.sfc_wr = 1'b0;
        map_check(8'hD0, 2, 1, "cm_old");
        map_check(8'hD7, 4, 1, "cm_new");
        idle();
        cyc();

        // reset in the middle of a write strobe
        bus.sfc_port = 4'd1;
        bus.sfc_data_in = 8'h03;
        bus.sfc_wr = 1'b1;
        repeat (2) cyc();
        #2 RESET_N = 1'b0;
        model_reset();
        #1 reset_outputs_zero("arst");
        bus.sfc_data_in = 8'h05;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) cyc();
        check("arst_nowr", bus.update_pending, 0);
        bus.sfc_wr = 1'b0;
        cyc();
        check("arst_nocm", bus.block_sel, 0);
        check("arst_nopd", bus.update_pending, 0);
        rd_check(1, 8'h00, "arst_rb");

        for (int n = 0; n < 600; n++) begin
            bus.bank_sfc_enable = ($urandom % 8) != 0;
            if ($urandom % 4 == 0) bus.sfc_wr = ~bus.sfc_wr;
            if ($urandom % 3 == 0) bus.sfc_rd = ~bus.sfc_rd;
            bus.sfc_port = ($urandom % 4 == 0) ? 4'($urandom % 16)
                                               : 4'($urandom % 4);
            bus.sfc_data_in = 8'($urandom);
            bus.map_req = $urandom % 2;
            bus.map_bank = ($urandom % 4 == 0) ? 8'($urandom)
                         : {4'(12 + $urandom % 4), 4'($urandom)};
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
